decode_stage: RTL and testbench

- Parametrised, registered multi-lane decode stage for the superscalar front end.
- Latches a fetch packet of LANES instructions and decodes each lane's opcode into a control word.
- Detects intra-packet RAW dependencies and splits the packet over several cycles.
- Sits between fetch and issue. Uses valid/ready handshakes on both sides, plus flush.

---
 rtl/decode_stage_pkg.sv | 31 +++
 rtl/decode_stage_lane_decode.sv | 87 ++++++++
 rtl/decode_stage.sv | 119 +++++++++++
 tb/tb_decode_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RISC-V major opcodes, per-lane control
// words and the default control-bus width.
package decode_stage_pkg;

  localparam int CTRL_WIDTH = 8;

  typedef logic [4:0] reg_idx_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_ALUI   = 7'h13;
  localparam logic [6:0] OP_ALUR   = 7'h33;

  localparam logic [CTRL_WIDTH-1:0] ALUI_CTRL   = 8'h01;
  localparam logic [CTRL_WIDTH-1:0] ALUR_CTRL   = 8'h02;
  localparam logic [CTRL_WIDTH-1:0] LUI_CTRL    = 8'h03;
  localparam logic [CTRL_WIDTH-1:0] AUIPC_CTRL  = 8'h04;
  localparam logic [CTRL_WIDTH-1:0] JAL_CTRL    = 8'h05;
  localparam logic [CTRL_WIDTH-1:0] JALR_CTRL   = 8'h06;
  localparam logic [CTRL_WIDTH-1:0] BRANCH_CTRL = 8'h07;
  localparam logic [CTRL_WIDTH-1:0] LOAD_CTRL   = 8'h08;
  localparam logic [CTRL_WIDTH-1:0] STORE_CTRL  = 8'h09;

  localparam logic [CTRL_WIDTH-1:0] INVALID_INST_CTRL = 8'hff;

endpackage

// File: rtl/decode_stage_lane_decode.sv
// Combinational single-lane decoder: control word plus register usage.
// Ports: valid/inst in; ctrl, writes_rd, uses_rs1/2, rd, rs1, rs2 out.
module lane_decode
  import decode_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter bit MEM_EN = 1'b0
) (
  input  logic              valid,
  input  logic [31:0]       inst,
  output logic [CTRL_W-1:0] ctrl,
  output logic              writes_rd,
  output logic              uses_rs1,
  output logic              uses_rs2,
  output reg_idx_t          rd,
  output reg_idx_t          rs1,
  output reg_idx_t          rs2
);

  logic [6:0] opc;
  logic       unused_bits;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  assign unused_bits = ^{inst[31:25], inst[14:12]};

  always_comb begin
    ctrl      = '0;
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    if (valid) begin
      // unknown opcodes keep this and touch no registers
      ctrl = CTRL_W'(INVALID_INST_CTRL);
      unique case (1'b1)
        opc == OP_ALUI: begin
          ctrl      = CTRL_W'(ALUI_CTRL);
          writes_rd = 1'b1;
          uses_rs1  = 1'b1;
        end
        opc == OP_ALUR: begin
          ctrl      = CTRL_W'(ALUR_CTRL);
          writes_rd = 1'b1;
          uses_rs1  = 1'b1;
          uses_rs2  = 1'b1;
        end
        opc == OP_LUI: begin
          ctrl      = CTRL_W'(LUI_CTRL);
          writes_rd = 1'b1;
        end
        opc == OP_AUIPC: begin
          ctrl      = CTRL_W'(AUIPC_CTRL);
          writes_rd = 1'b1;
        end
        opc == OP_JAL: begin
          ctrl      = CTRL_W'(JAL_CTRL);
          writes_rd = 1'b1;
        end
        opc == OP_JALR: begin
          ctrl      = CTRL_W'(JALR_CTRL);
          writes_rd = 1'b1;
          uses_rs1  = 1'b1;
        end
        opc == OP_BRANCH: begin
          ctrl     = CTRL_W'(BRANCH_CTRL);
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
        end
        opc == OP_LOAD && MEM_EN: begin
          ctrl      = CTRL_W'(LOAD_CTRL);
          writes_rd = 1'b1;
          uses_rs1  = 1'b1;
        end
        opc == OP_STORE && MEM_EN: begin
          ctrl     = CTRL_W'(STORE_CTRL);
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Multi-lane registered decode stage; splits packets on intra-packet RAW.
// Ports: fetch side in_*, issue side out_*, flush_i, split_cnt_o stats.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int CTRL_W = CTRL_WIDTH,
  parameter bit MEM_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [LANES-1:0]        in_valid_i,
  input  logic [LANES*32-1:0]     in_inst_i,
  input  logic [LANES*32-1:0]     in_pc_i,
  output logic                    in_ready_o,
  output logic [LANES-1:0]        out_valid_o,
  output logic [LANES*32-1:0]     out_inst_o,
  output logic [LANES*32-1:0]     out_pc_o,
  output logic [LANES*CTRL_W-1:0] out_ctrl_o,
  input  logic                    out_ready_i,
  input  logic                    flush_i,
  output logic [CNT_W-1:0]        split_cnt_o
);

  logic [LANES-1:0]    pending_q;
  logic [LANES*32-1:0] inst_q;
  logic [LANES*32-1:0] pc_q;

  logic [LANES-1:0] wr;
  logic [LANES-1:0] u1;
  logic [LANES-1:0] u2;
  reg_idx_t         rd  [LANES];
  reg_idx_t         rs1 [LANES];
  reg_idx_t         rs2 [LANES];

  logic [LANES-1:0] haz;
  logic [LANES-1:0] group;
  logic [LANES-1:0] remain;
  logic             blocked;
  logic             accept;
  logic             issue;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_decode #(
      .CTRL_W (CTRL_W),
      .MEM_EN (MEM_EN)
    ) u_dec (
      .valid     (pending_q[g]),
      .inst      (inst_q[g*32 +: 32]),
      .ctrl      (out_ctrl_o[g*CTRL_W +: CTRL_W]),
      .writes_rd (wr[g]),
      .uses_rs1  (u1[g]),
      .uses_rs2  (u2[g]),
      .rd        (rd[g]),
      .rs1       (rs1[g]),
      .rs2       (rs2[g])
    );
  end

  // usage flags are already gated by pending, so haz implies pending
  always_comb begin
    haz = '0;
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (wr[i] && rd[i] != 5'd0 &&
            ((u1[j] && rs1[j] == rd[i]) ||
             (u2[j] && rs2[j] == rd[i])))
          haz[j] = 1'b1;
      end
    end
  end

  // group = pending lanes strictly below the first hazardous lane
  always_comb begin
    group   = '0;
    blocked = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      blocked  = blocked | haz[k];
      group[k] = pending_q[k] & ~blocked;
    end
  end

  assign remain = pending_q & ~group;

  assign in_ready_o = !flush_i &&
                      (pending_q == '0 ||
                       (out_ready_i && group == pending_q));

  assign accept = in_ready_o && |in_valid_i;
  assign issue  = !flush_i && out_ready_i && |group;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      split_cnt_o <= '0;
    end else if (flush_i) begin
      pending_q <= '0;
    end else if (accept) begin
      pending_q <= in_valid_i;
    end else if (issue) begin
      pending_q <= remain;
      if (|remain && split_cnt_o != '1)
        split_cnt_o <= split_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      inst_q <= in_inst_i;
      pc_q   <= in_pc_i;
    end
  end

  assign out_valid_o = group;
  assign out_inst_o  = inst_q;
  assign out_pc_o    = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed packets, literal checks and a
// cycle-by-cycle reference model for two configurations.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [63:0] in_inst;
  logic [63:0] in_pc;
  logic        out_ready;
  logic        flush;

  logic        in_ready0, in_ready1;
  logic [1:0]  out_valid0, out_valid1;
  logic [63:0] out_inst0, out_inst1;
  logic [63:0] out_pc0, out_pc1;
  logic [15:0] out_ctrl0, out_ctrl1;
  logic [15:0] split0;
  logic [1:0]  split1;

  int total = 0;
  int bad   = 0;
  logic [31:0] pc_base = 32'h1000;

  decode_stage #(
    .LANES(2), .CTRL_W(8), .MEM_EN(1'b1), .CNT_W(16)
  ) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_inst_i   (in_inst),
    .in_pc_i     (in_pc),
    .in_ready_o  (in_ready0),
    .out_valid_o (out_valid0),
    .out_inst_o  (out_inst0),
    .out_pc_o    (out_pc0),
    .out_ctrl_o  (out_ctrl0),
    .out_ready_i (out_ready),
    .flush_i     (flush),
    .split_cnt_o (split0)
  );

  decode_stage #(
    .LANES(2), .CTRL_W(8), .MEM_EN(1'b0), .CNT_W(2)
  ) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_inst_i   (in_inst),
    .in_pc_i     (in_pc),
    .in_ready_o  (in_ready1),
    .out_valid_o (out_valid1),
    .out_inst_o  (out_inst1),
    .out_pc_o    (out_pc1),
    .out_ctrl_o  (out_ctrl1),
    .out_ready_i (out_ready),
    .flush_i     (flush),
    .split_cnt_o (split1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  ov [2];
  logic        ir [2];
  logic [15:0] oc [2];
  logic [63:0] oi [2];
  logic [63:0] op [2];
  logic [15:0] sc [2];

  assign ov[0] = out_valid0;
  assign ov[1] = out_valid1;
  assign ir[0] = in_ready0;
  assign ir[1] = in_ready1;
  assign oc[0] = out_ctrl0;
  assign oc[1] = out_ctrl1;
  assign oi[0] = out_inst0;
  assign oi[1] = out_inst1;
  assign op[0] = out_pc0;
  assign op[1] = out_pc1;
  assign sc[0] = split0;
  assign sc[1] = {14'd0, split1};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1,
                                       input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1,
                                      input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] lui(input int rd, input int imm);
    return {20'(imm), 5'(rd), 7'h37};
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1,
                                     input int off);
    return {12'(off), 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1,
                                     input int off);
    logic [11:0] o;
    o = 12'(off);
    return {o[11:5], 5'(rs2), 5'(rs1), 3'b010, o[4:0], 7'h23};
  endfunction

  // reference model: per-DUT pending mask, buffer and counter
  logic [1:0]  m_pend [2] = '{2'b00, 2'b00};
  logic [31:0] m_inst [2][2];
  logic [31:0] m_pc   [2][2];
  int          m_cnt  [2] = '{0, 0};
  int          m_max  [2] = '{65535, 3};

  function automatic void mdec(input logic [31:0] ins, input logic v,
                               input bit memen, output logic [7:0] c,
                               output bit wr, output bit a,
                               output bit b);
    c = 8'h00; wr = 0; a = 0; b = 0;
    if (v) begin
      case (ins[6:0])
        7'h13: begin c = 8'h01; wr = 1; a = 1; end
        7'h33: begin c = 8'h02; wr = 1; a = 1; b = 1; end
        7'h37: begin c = 8'h03; wr = 1; end
        7'h17: begin c = 8'h04; wr = 1; end
        7'h6f: begin c = 8'h05; wr = 1; end
        7'h67: begin c = 8'h06; wr = 1; a = 1; end
        7'h63: begin c = 8'h07; a = 1; b = 1; end
        7'h03: if (memen) begin c = 8'h08; wr = 1; a = 1; end
               else c = 8'hff;
        7'h23: if (memen) begin c = 8'h09; a = 1; b = 1; end
               else c = 8'hff;
        default: c = 8'hff;
      endcase
    end
  endfunction

  // walk lanes in order, collecting written registers; stop at the
  // first lane that reads one of them
  function automatic logic [1:0] m_group(input int d);
    logic [31:0] wset;
    logic [1:0]  g;
    logic [7:0]  c;
    logic [31:0] ins;
    bit          wr, a, b;
    wset = '0;
    g = '0;
    for (int j = 0; j < 2; j++) begin
      if (m_pend[d][j]) begin
        ins = m_inst[d][j];
        mdec(ins, 1'b1, d == 0, c, wr, a, b);
        if ((a && wset[ins[19:15]]) || (b && wset[ins[24:20]]))
          break;
        g[j] = 1'b1;
        if (wr && ins[11:7] != 5'd0) wset[ins[11:7]] = 1'b1;
      end
    end
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] g;
    logic       rdy;
    if (rst) begin
      m_pend = '{2'b00, 2'b00};
      m_cnt  = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        g = m_group(d);
        rdy = !flush && (m_pend[d] == 2'b00 ||
                         (out_ready && g == m_pend[d]));
        if (flush) begin
          m_pend[d] = 2'b00;
        end else if (rdy && in_valid != 2'b00) begin
          m_pend[d] = in_valid;
          m_inst[d][0] = in_inst[31:0];
          m_inst[d][1] = in_inst[63:32];
          m_pc[d][0] = in_pc[31:0];
          m_pc[d][1] = in_pc[63:32];
        end else if (out_ready && g != 2'b00) begin
          m_pend[d] = m_pend[d] & ~g;
          if (m_pend[d] != 2'b00 && m_cnt[d] < m_max[d])
            m_cnt[d]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    logic       rdy;
    logic [7:0] c;
    bit         wr, a, b;
    for (int d = 0; d < 2; d++) begin
      g = m_group(d);
      rdy = !flush && (m_pend[d] == 2'b00 ||
                       (out_ready && g == m_pend[d]));
      chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(g));
      chk($sformatf("d%0d in_ready", d), 64'(ir[d]), 64'(rdy));
      chk($sformatf("d%0d split_cnt", d), 64'(sc[d]),
          64'(m_cnt[d]));
      for (int l = 0; l < 2; l++) begin
        mdec(m_inst[d][l], m_pend[d][l], d == 0, c, wr, a, b);
        chk($sformatf("d%0d ctrl%0d", d, l),
            64'(oc[d][l*8 +: 8]), 64'(c));
        if (m_pend[d][l]) begin
          chk($sformatf("d%0d inst%0d", d, l),
              64'(oi[d][l*32 +: 32]), 64'(m_inst[d][l]));
          chk($sformatf("d%0d pc%0d", d, l),
              64'(op[d][l*32 +: 32]), 64'(m_pc[d][l]));
        end
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] i0,
                       input logic [31:0] i1, input logic ordy,
                       input logic fl);
    #1;
    in_valid  = v;
    in_inst   = {i1, i0};
    in_pc     = {pc_base + 32'd4, pc_base};
    pc_base   = pc_base + 32'd8;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_inst = '0;
    in_pc = '0;
    out_ready = 1'b0;
    flush = 1'b0;

    @(negedge clk);
    chk("rst out_valid", 64'(out_valid0), 64'h0);
    chk("rst in_ready", 64'(in_ready0), 64'h1);
    chk("rst split", 64'(split0), 64'h0);
    #1 rst = 1'b0;

    // independent pair, streaming
    @(negedge clk);
    drive(2'b11, addi(1, 0, 1), addi(2, 0, 2), 1'b1, 1'b0);
    @(negedge clk);
    chk("pair valid", 64'(out_valid0), 64'h3);
    chk("pair ctrl", 64'(out_ctrl0), 64'h0101);
    chk("pair ready", 64'(in_ready0), 64'h1);
    drive(2'b11, addi(3, 0, 3), addi(4, 0, 4), 1'b1, 1'b0);
    @(negedge clk);
    chk("stream valid", 64'(out_valid0), 64'h3);
    chk("stream inst", 64'(out_inst0[31:0]), 64'(addi(3, 0, 3)));
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain valid", 64'(out_valid0), 64'h0);

    // RAW split
    drive(2'b11, addi(5, 0, 1), add(6, 5, 5), 1'b1, 1'b0);
    @(negedge clk);
    chk("raw c1 valid", 64'(out_valid0), 64'h1);
    chk("raw c1 ready", 64'(in_ready0), 64'h0);
    chk("raw c1 ctrl", 64'(out_ctrl0), 64'h0201);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("raw c2 valid", 64'(out_valid0), 64'h2);
    chk("raw split", 64'(split0), 64'h1);
    chk("raw c2 ready", 64'(in_ready0), 64'h1);
    @(negedge clk);

    // rd = x0 and no-use cases
    drive(2'b11, addi(0, 0, 3), add(1, 0, 0), 1'b1, 1'b0);
    @(negedge clk);
    chk("x0 valid", 64'(out_valid0), 64'h3);
    drive(2'b11, addi(5, 0, 1), lui(5, 7), 1'b1, 1'b0);
    @(negedge clk);
    chk("nouse valid", 64'(out_valid0), 64'h3);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("nosplit cnt", 64'(split0), 64'h1);

    // invalid lanes and MEM_EN
    drive(2'b11, addi(1, 0, 1), 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("inv ctrl", 64'(out_ctrl0), 64'hff01);
    drive(2'b01, addi(1, 0, 1), add(2, 1, 1), 1'b1, 1'b0);
    @(negedge clk);
    chk("nv valid", 64'(out_valid0), 64'h1);
    chk("nv ctrl", 64'(out_ctrl0), 64'h0001);
    drive(2'b11, lw(3, 1, 0), sw(4, 2, 4), 1'b1, 1'b0);
    @(negedge clk);
    chk("mem ctrl", 64'(out_ctrl0), 64'h0908);
    chk("nomem ctrl", 64'(out_ctrl1), 64'hffff);
    drive(2'b11, lw(3, 1, 0), sw(3, 2, 0), 1'b1, 1'b0);
    @(negedge clk);
    chk("memraw valid", 64'(out_valid0), 64'h1);
    chk("nomem valid", 64'(out_valid1), 64'h3);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("memraw c2", 64'(out_valid0), 64'h2);
    chk("memraw split", 64'(split0), 64'h2);
    chk("nomem split", 64'(split1), 64'h1);
    @(negedge clk);

    // flush in PARTIAL with a packet waiting
    drive(2'b11, addi(5, 0, 1), add(6, 5, 5), 1'b1, 1'b0);
    @(negedge clk);
    chk("fp c1 valid", 64'(out_valid0), 64'h1);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fp partial", 64'(out_valid0), 64'h2);
    chk("fp split", 64'(split0), 64'h3);
    drive(2'b11, addi(1, 0, 1), addi(2, 0, 2), 1'b1, 1'b1);
    #1;
    chk("flush ready", 64'(in_ready0), 64'h0);
    @(negedge clk);
    chk("flush valid", 64'(out_valid0), 64'h0);
    chk("flush split", 64'(split0), 64'h3);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush drop", 64'(out_valid0), 64'h0);

    // flush a full hazardous packet: no split is counted
    drive(2'b11, addi(5, 0, 1), add(6, 5, 5), 1'b1, 1'b0);
    @(negedge clk);
    chk("ff c1 valid", 64'(out_valid0), 64'h1);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ff valid", 64'(out_valid0), 64'h0);
    chk("ff split", 64'(split0), 64'h3);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    // backpressure holds outputs
    drive(2'b11, addi(7, 0, 7), addi(8, 0, 8), 1'b0, 1'b0);
    @(negedge clk);
    chk("bp valid", 64'(out_valid0), 64'h3);
    chk("bp ready", 64'(in_ready0), 64'h0);
    drive(2'b11, addi(9, 0, 9), addi(10, 0, 10), 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("bp hold inst", out_inst0,
          {addi(8, 0, 8), addi(7, 0, 7)});
      chk("bp hold valid", 64'(out_valid0), 64'h3);
    end
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp release", 64'(out_valid0), 64'h0);

    // more splits: the 2-bit counter saturates
    repeat (3) begin
      drive(2'b11, addi(5, 0, 1), add(6, 5, 5), 1'b1, 1'b0);
      @(negedge clk);
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
    end
    chk("sat split0", 64'(split0), 64'h6);
    chk("sat split1", 64'(split1), 64'h3);

    // asynchronous reset while a packet is pending
    drive(2'b11, addi(1, 0, 1), addi(2, 0, 2), 1'b0, 1'b0);
    @(negedge clk);
    chk("pre rst valid", 64'(out_valid0), 64'h3);
    #2 rst = 1'b1;
    #1;
    chk("arst valid", 64'(out_valid0), 64'h0);
    chk("arst ready", 64'(in_ready0), 64'h1);
    chk("arst split0", 64'(split0), 64'h0);
    chk("arst split1", 64'(split1), 64'h0);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
